// File: rtl/jedro_1_lsu_pkg.sv
// Shared definitions for the jedro_1 load-store unit: size encoding, FSM states
// and the alignment rule applied to every incoming request.
package jedro_1_defines;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Size 2'b11 has no legal encoding, so it is reported as misaligned.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LSU_BYTE: mis = 1'b0;
      LSU_HALF: mis = addr_lo[0];
      LSU_WORD: mis = |addr_lo;
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/jedro_1_lsu_align.sv
// Combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads.
module jedro_1_lsu_align
  import jedro_1_defines::*;
(
  input  logic        store_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rdata_shifted;

  always_comb begin
    we_o    = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      LSU_BYTE: begin
        we_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      LSU_HALF: begin
        we_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      LSU_WORD: we_o = 4'b1111;
      default:  we_o = 4'b0000;
    endcase
    if (!store_i) begin
      we_o = 4'b0000;
    end
  end

  always_comb begin
    rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
    rdata_o       = rdata_shifted;
    case (size_i)
      LSU_BYTE: rdata_o = unsigned_i ? {24'b0, rdata_shifted[7:0]}
                                     : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      LSU_HALF: rdata_o = unsigned_i ? {16'b0, rdata_shifted[15:0]}
                                     : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default:  rdata_o = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: accepts one load/store, runs one stb/ack bus cycle
// with timeout, and returns registered write-back or exception strobes.
module jedro_1_lsu
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  output logic                      ctrl_ready_o,
  input  logic                      ctrl_we_i,
  input  logic [1:0]                ctrl_size_i,
  input  logic                      ctrl_unsigned_i,
  input  logic [REG_ADDR_WIDTH-1:0] ctrl_regdest_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      rf_wb_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_dest_o,
  output logic [DATA_WIDTH-1:0]     rf_data_o,
  output logic                      misaligned_o,
  output logic                      bus_err_o,
  output logic [ADDR_WIDTH-1:0]     exc_addr_o,
  output logic [3:0]                dram_we_o,
  output logic                      dram_stb_o,
  output logic [ADDR_WIDTH-1:0]     dram_addr_o,
  output logic [DATA_WIDTH-1:0]     dram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     dram_rdata_i,
  input  logic                      dram_ack_i,
  input  logic                      dram_err_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  lsu_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [1:0]                size_q, size_d;
  logic                      uns_q, uns_d;
  logic [REG_ADDR_WIDTH-1:0] regdest_q, regdest_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      misal_q, misal_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;

  logic [3:0]            lane_we;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] rdata_ext;

  jedro_1_lsu_align u_align (
    .store_i    (we_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (dram_rdata_i),
    .we_o       (lane_we),
    .wdata_o    (lane_wdata),
    .rdata_o    (rdata_ext)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    regdest_d = regdest_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    misal_d   = misal_q;
    err_d     = err_q;
    rf_data_d = rf_data_q;
    case (state_q)
      IDLE: begin
        if (ctrl_valid_i) begin
          we_d      = ctrl_we_i;
          size_d    = ctrl_size_i;
          uns_d     = ctrl_unsigned_i;
          regdest_d = ctrl_regdest_i;
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          misal_d   = lsu_misaligned(ctrl_size_i, addr_i[1:0]);
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = misal_d ? RESP : BUS;
        end
      end
      BUS: begin
        // err has priority so a simultaneous ack never produces a write-back.
        if (dram_err_i) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (dram_ack_i) begin
          if (!we_q) begin
            rf_data_d = rdata_ext;
          end
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      regdest_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      misal_q   <= 1'b0;
      err_q     <= 1'b0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      regdest_q <= regdest_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      misal_q   <= misal_d;
      err_q     <= err_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Outputs decode only registered state, so reset drops them immediately.
  assign ctrl_ready_o = (state_q == IDLE);
  assign dram_stb_o   = (state_q == BUS);
  assign dram_we_o    = dram_stb_o ? lane_we : 4'b0000;
  assign dram_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dram_wdata_o = lane_wdata;
  assign rf_wb_o      = (state_q == RESP) && !we_q && !misal_q && !err_q;
  assign misaligned_o = (state_q == RESP) && misal_q;
  assign bus_err_o    = (state_q == RESP) && err_q;
  assign rf_dest_o    = regdest_q;
  assign rf_data_o    = rf_data_q;
  assign exc_addr_o   = addr_q;

endmodule
